morse_char_tx: RTL and testbench

//   Transmit side of the Morse path: converts a letter code into a timed on/off key stream.
//   It drives an LED or buzzer and is the counterpart to the KEY-press dot/dash input parser.
//   It sits on the same divided clock in the DE1_SoC top and takes one letter per valid/ready handshake.
//   Per letter it emits the ITU Morse marks, the inter-symbol gaps and the trailing character gap.

---
 rtl/morse_char_tx.sv | 187 ++++++++++++++++++
 tb/tb_morse_char_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_tx.sv
// Morse transmitter: turns one letter index per handshake into timed
// key-down marks, inter-symbol gaps and a trailing character gap.
module morse_char_tx #(
    parameter int unsigned UNIT_CYCLES    = 1,
    parameter int unsigned DASH_UNITS     = 3,
    parameter int unsigned CHAR_GAP_UNITS = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [4:0] charIn,
    input  logic       charValid,
    output logic       charReady,
    output logic       keyOut,
    output logic       dotOut,
    output logic       dashOut,
    output logic       busy,
    output logic       badChar
);

    localparam int unsigned DOT_LEN  = UNIT_CYCLES;
    localparam int unsigned DASH_LEN = DASH_UNITS * UNIT_CYCLES;
    localparam int unsigned GAP_LEN  = CHAR_GAP_UNITS * UNIT_CYCLES;
    localparam int unsigned MAX_A    = (DASH_LEN > DOT_LEN) ? DASH_LEN : DOT_LEN;
    localparam int unsigned MAX_LEN  = (GAP_LEN > MAX_A) ? GAP_LEN : MAX_A;
    localparam int unsigned CW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] DOT_END  = CW'(DOT_LEN - 1);
    localparam logic [CW-1:0] DASH_END = CW'(DASH_LEN - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SYMGAP,
        S_CHARGAP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [2:0]    r_len;
    logic [3:0]    r_pat;
    logic          r_key;
    logic          r_dot;
    logic          r_dash;
    logic          r_busy;
    logic          r_bad;

    state_t        w_nxt_state;
    logic [CW-1:0] w_nxt_cnt;
    logic [1:0]    w_nxt_idx;
    logic [2:0]    w_nxt_len;
    logic [3:0]    w_nxt_pat;
    logic          w_nxt_bit;
    logic          w_bad;
    logic [2:0]    w_rom_len;
    logic [3:0]    w_rom_pat;
    logic          w_rom_valid;
    logic          w_accept;
    logic          w_cur_bit;
    logic          w_mark_end;
    logic          w_last;

    // Patterns are left-aligned: bit 3 is the first symbol, 1 = dash.
    always_comb begin
        w_rom_len = 3'd0;
        w_rom_pat = 4'b0000;
        unique case (charIn)
            5'd0:  begin w_rom_len = 3'd2; w_rom_pat = 4'b0100; end
            5'd1:  begin w_rom_len = 3'd4; w_rom_pat = 4'b1000; end
            5'd2:  begin w_rom_len = 3'd4; w_rom_pat = 4'b1010; end
            5'd3:  begin w_rom_len = 3'd3; w_rom_pat = 4'b1000; end
            5'd4:  begin w_rom_len = 3'd1; w_rom_pat = 4'b0000; end
            5'd5:  begin w_rom_len = 3'd4; w_rom_pat = 4'b0010; end
            5'd6:  begin w_rom_len = 3'd3; w_rom_pat = 4'b1100; end
            5'd7:  begin w_rom_len = 3'd4; w_rom_pat = 4'b0000; end
            5'd8:  begin w_rom_len = 3'd2; w_rom_pat = 4'b0000; end
            5'd9:  begin w_rom_len = 3'd4; w_rom_pat = 4'b0111; end
            5'd10: begin w_rom_len = 3'd3; w_rom_pat = 4'b1010; end
            5'd11: begin w_rom_len = 3'd4; w_rom_pat = 4'b0100; end
            5'd12: begin w_rom_len = 3'd2; w_rom_pat = 4'b1100; end
            5'd13: begin w_rom_len = 3'd2; w_rom_pat = 4'b1000; end
            5'd14: begin w_rom_len = 3'd3; w_rom_pat = 4'b1110; end
            5'd15: begin w_rom_len = 3'd4; w_rom_pat = 4'b0110; end
            5'd16: begin w_rom_len = 3'd4; w_rom_pat = 4'b1101; end
            5'd17: begin w_rom_len = 3'd3; w_rom_pat = 4'b0100; end
            5'd18: begin w_rom_len = 3'd3; w_rom_pat = 4'b0000; end
            5'd19: begin w_rom_len = 3'd1; w_rom_pat = 4'b1000; end
            5'd20: begin w_rom_len = 3'd3; w_rom_pat = 4'b0010; end
            5'd21: begin w_rom_len = 3'd4; w_rom_pat = 4'b0001; end
            5'd22: begin w_rom_len = 3'd3; w_rom_pat = 4'b0110; end
            5'd23: begin w_rom_len = 3'd4; w_rom_pat = 4'b1001; end
            5'd24: begin w_rom_len = 3'd4; w_rom_pat = 4'b1011; end
            5'd25: begin w_rom_len = 3'd4; w_rom_pat = 4'b1100; end
            default: begin w_rom_len = 3'd0; w_rom_pat = 4'b0000; end
        endcase
    end

    assign w_rom_valid = (charIn <= 5'd25);
    assign w_accept    = charValid & (r_state == S_IDLE);
    assign w_cur_bit   = r_pat[2'd3 - r_idx];
    assign w_mark_end  = (r_cnt == (w_cur_bit ? DASH_END : DOT_END));
    assign w_last      = ({1'b0, r_idx} == (r_len - 3'd1));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_nxt_idx   = r_idx;
        w_nxt_len   = r_len;
        w_nxt_pat   = r_pat;
        w_bad       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_nxt_cnt = '0;
                if (w_accept) begin
                    if (w_rom_valid) begin
                        w_nxt_state = S_MARK;
                        w_nxt_idx   = 2'd0;
                        w_nxt_len   = w_rom_len;
                        w_nxt_pat   = w_rom_pat;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            S_MARK: begin
                if (w_mark_end) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = w_last ? S_CHARGAP : S_SYMGAP;
                end
            end
            S_SYMGAP: begin
                if (r_cnt == DOT_END) begin
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = r_idx + 2'd1;
                    w_nxt_state = S_MARK;
                end
            end
            S_CHARGAP: begin
                if (r_cnt == GAP_END) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_cnt   = '0;
                w_nxt_state = S_IDLE;
            end
        endcase
        w_nxt_bit = w_nxt_pat[2'd3 - w_nxt_idx];
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_pat   <= '0;
            r_key   <= 1'b0;
            r_dot   <= 1'b0;
            r_dash  <= 1'b0;
            r_busy  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_idx   <= w_nxt_idx;
            r_len   <= w_nxt_len;
            r_pat   <= w_nxt_pat;
            r_key   <= (w_nxt_state == S_MARK);
            r_dot   <= (w_nxt_state == S_MARK) & ~w_nxt_bit;
            r_dash  <= (w_nxt_state == S_MARK) & w_nxt_bit;
            r_busy  <= (w_nxt_state != S_IDLE);
            r_bad   <= w_bad;
        end
    end

    assign charReady = (r_state == S_IDLE);
    assign keyOut    = r_key;
    assign dotOut    = r_dot;
    assign dashOut   = r_dash;
    assign busy      = r_busy;
    assign badChar   = r_bad;

endmodule

// File: tb/tb_morse_char_tx.sv
// Directed bench for morse_char_tx: letters E, A, Q (two-cycle unit),
// invalid index, reset abort and back-to-back acceptance.
module tb_morse_char_tx;

    logic       clk;
    logic       rst;
    logic [4:0] ch1;
    logic       v1;
    logic       rdy1, key1, dot1, dash1, busy1, bad1;
    logic [4:0] ch2;
    logic       v2;
    logic       rdy2, key2, dot2, dash2, busy2, bad2;

    int n_checks;
    int n_errors;

    morse_char_tx #(.UNIT_CYCLES(1), .DASH_UNITS(3), .CHAR_GAP_UNITS(3)) dut (
        .Clock(clk), .Reset(rst), .charIn(ch1), .charValid(v1),
        .charReady(rdy1), .keyOut(key1), .dotOut(dot1), .dashOut(dash1),
        .busy(busy1), .badChar(bad1)
    );

    morse_char_tx #(.UNIT_CYCLES(2), .DASH_UNITS(3), .CHAR_GAP_UNITS(3)) dut2 (
        .Clock(clk), .Reset(rst), .charIn(ch2), .charValid(v2),
        .charReady(rdy2), .keyOut(key2), .dotOut(dot2), .dashOut(dash2),
        .busy(busy2), .badChar(bad2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic accept1(input logic [4:0] c);
        @(negedge clk);
        ch1 = c;
        v1  = 1'b1;
        @(posedge clk);
        #1;
        v1  = 1'b0;
        ch1 = 5'd17;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b1; ch1 = 5'd4;
        v2 = 1'b1; ch2 = 5'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({key1, dot1, dash1, busy1, bad1, rdy1} !== 6'b000001) begin
            n_errors++;
            $display("FAIL reset_dut1 got=%b want=000001",
                     {key1, dot1, dash1, busy1, bad1, rdy1});
        end
        n_checks++;
        if ({key2, dot2, dash2, busy2, bad2, rdy2} !== 6'b000001) begin
            n_errors++;
            $display("FAIL reset_dut2 got=%b want=000001",
                     {key2, dot2, dash2, busy2, bad2, rdy2});
        end
        v1 = 1'b0; v2 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_e(input string tag);
        logic [4:0] exp_key, exp_rdy, exp_busy;
        exp_key  = 5'b10000;
        exp_rdy  = 5'b00001;
        exp_busy = 5'b11110;
        accept1(5'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({key1, rdy1, busy1, dot1, dash1} !==
                {exp_key[4-i], exp_rdy[4-i], exp_busy[4-i], exp_key[4-i], 1'b0}) begin
                n_errors++;
                $display("FAIL %s cyc=k+%0d key/rdy/busy/dot/dash got=%b%b%b%b%b want=%b%b%b%b0",
                         tag, i + 1, key1, rdy1, busy1, dot1, dash1,
                         exp_key[4-i], exp_rdy[4-i], exp_busy[4-i], exp_key[4-i]);
            end
        end
    endtask

    task automatic test_e();
        check_e("letter_E");
    endtask

    task automatic test_a();
        logic [8:0] exp_key, exp_dot, exp_dash, exp_rdy;
        exp_key  = 9'b101110000;
        exp_dot  = 9'b100000000;
        exp_dash = 9'b001110000;
        exp_rdy  = 9'b000000001;
        accept1(5'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_checks++;
            if ({key1, dot1, dash1, rdy1} !==
                {exp_key[8-i], exp_dot[8-i], exp_dash[8-i], exp_rdy[8-i]}) begin
                n_errors++;
                $display("FAIL letter_A cyc=k+%0d key/dot/dash/rdy got=%b%b%b%b want=%b%b%b%b",
                         i + 1, key1, dot1, dash1, rdy1,
                         exp_key[8-i], exp_dot[8-i], exp_dash[8-i], exp_rdy[8-i]);
            end
        end
    endtask

    task automatic test_q_unit2();
        int   seg_len [8];
        logic seg_key [8];
        logic seg_dash[8];
        int   cyc;
        seg_len  = '{6, 2, 6, 2, 2, 2, 6, 6};
        seg_key  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_dash = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        cyc = 0;
        @(negedge clk);
        ch2 = 5'd16;
        v2  = 1'b1;
        @(posedge clk);
        #1;
        v2  = 1'b0;
        ch2 = 5'd0;
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < seg_len[s]; j++) begin
                @(negedge clk);
                cyc++;
                n_checks++;
                if ({key2, dash2, dot2, busy2, rdy2} !==
                    {seg_key[s], seg_dash[s], seg_key[s] & ~seg_dash[s], 1'b1, 1'b0}) begin
                    n_errors++;
                    $display("FAIL letter_Q_u2 cyc=k+%0d key/dash/dot/busy/rdy got=%b%b%b%b%b want=%b%b%b10",
                             cyc, key2, dash2, dot2, busy2, rdy2,
                             seg_key[s], seg_dash[s], seg_key[s] & ~seg_dash[s]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if ({rdy2, busy2, key2} !== 3'b100) begin
            n_errors++;
            $display("FAIL letter_Q_u2_done rdy/busy/key got=%b%b%b want=100",
                     rdy2, busy2, key2);
        end
    endtask

    task automatic test_invalid();
        accept1(5'd27);
        @(negedge clk);
        n_checks++;
        if ({bad1, key1, rdy1, busy1} !== 4'b1010) begin
            n_errors++;
            $display("FAIL invalid_k1 bad/key/rdy/busy got=%b%b%b%b want=1010",
                     bad1, key1, rdy1, busy1);
        end
        @(negedge clk);
        n_checks++;
        if ({bad1, key1, rdy1, busy1} !== 4'b0010) begin
            n_errors++;
            $display("FAIL invalid_k2 bad/key/rdy/busy got=%b%b%b%b want=0010",
                     bad1, key1, rdy1, busy1);
        end
    endtask

    task automatic test_reset_mid();
        accept1(5'd19);
        @(negedge clk);
        n_checks++;
        if ({key1, dash1} !== 2'b11) begin
            n_errors++;
            $display("FAIL abort_dash1 key/dash got=%b%b want=11", key1, dash1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({key1, dash1, busy1} !== 3'b111) begin
            n_errors++;
            $display("FAIL abort_dash2 key/dash/busy got=%b%b%b want=111",
                     key1, dash1, busy1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({key1, busy1, rdy1} !== 3'b001) begin
            n_errors++;
            $display("FAIL abort_after key/busy/rdy got=%b%b%b want=001",
                     key1, busy1, rdy1);
        end
        check_e("after_abort_E");
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_key, exp_rdy;
        exp_key = 10'b1000010000;
        exp_rdy = 10'b0000100001;
        @(negedge clk);
        ch1 = 5'd4;
        v1  = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({key1, rdy1} !== {exp_key[9-i], exp_rdy[9-i]}) begin
                n_errors++;
                $display("FAIL b2b cyc=k+%0d key/rdy got=%b%b want=%b%b",
                         i + 1, key1, rdy1, exp_key[9-i], exp_rdy[9-i]);
            end
            if (i == 5) v1 = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ch1 = 5'd0; v1 = 1'b0;
        ch2 = 5'd0; v2 = 1'b0;
        rst = 1'b1;
        test_reset();
        test_e();
        test_a();
        test_q_unit2();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
